fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch front end of the pipelined MIPS core. It owns the program counter, drives the fetch address into the instruction memory, and captures the returned word into the IF/ID pipeline register. It resolves stall, branch/jump redirect, exception entry and ERET return in a fixed priority order. It also flags fetch address errors and counts fetched instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; base of the instruction window
- EXC_PC, 32'h0000_4180, exception handler entry address
- ADR_BITS, 12, instruction window holds 2^ADR_BITS words starting at RESET_PC

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and IF/ID (hazard from D stage)
- redirect_valid  in  1  branch/jump taken in D stage
- redirect_pc  in  32  branch/jump target
- exc_req  in  1  exception entry request
- eret_req  in  1  return from exception
- epc  in  32  return address for ERET
- imem_pc  out  32  fetch address to instruction memory
- imem_instr  in  32  instruction word from memory, combinational on imem_pc
- if_id_instr  out  32  captured instruction
- if_id_pc  out  32  PC of captured instruction
- if_id_valid  out  1  IF/ID holds a real fetch, not a bubble
- if_id_adel  out  1  captured fetch had an address error
- fetch_cnt  out  32  number of valid entries loaded into IF/ID

## Operation
- State elements: pc, IF/ID register (instr, pc, valid, adel) and fetch_cnt.
- imem_pc = pc, with no logic in between.
- next_pc priority, highest first:
  1. exc_req: EXC_PC
  2. eret_req: epc
  3. stall: hold pc
  4. redirect_valid: redirect_pc
  5. otherwise: pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0)
- When stall=1, redirect_valid is ignored. D stage reasserts it once the stall clears.
- exc_req and eret_req both asserted: exc_req wins and eret_req is dropped.
- IF/ID update, highest priority first:
  - exc_req or eret_req: load a bubble (instr=0, pc=0, valid=0, adel=0).
  - stall: hold all fields.
  - otherwise: instr=imem_instr, pc=pc, valid=1, adel=adel_now.
- There is no flush on redirect. The word fetched in the same cycle is the delay slot and is captured normally.
- adel_now = (pc[1:0] != 0) or (pc < RESET_PC) or (pc >= RESET_PC + 4*2^ADR_BITS).
  - Bounds are compared unsigned on 32 bits.
  - When adel_now=1, instr is loaded as 0 instead of imem_instr.
- fetch_cnt increments by 1 (wrapping at 2^32) on each edge that loads IF/ID with valid=1, including entries with adel=1.
- Reset values:
  - pc = RESET_PC, hence imem_pc = RESET_PC.
  - if_id_instr = 0, if_id_pc = 0, if_id_valid = 0, if_id_adel = 0.
  - fetch_cnt = 0.

## Timing
- Latency is one cycle: the word at pc appears on if_id_instr after the next rising edge.
- Redirect and exception targets take effect on imem_pc after the edge where they are sampled. They appear in IF/ID one edge later.
- Reset deassertion:
  - The first edge with reset_n=1 captures the word at RESET_PC.
  - if_id_valid=1 from that edge on, unless stalled.
- Reset mid-operation clears all state immediately, independent of clk.
- Stall held for N cycles: all outputs stay constant for N edges and fetch_cnt does not change.
- Simultaneous stall and exc_req: the exception is taken. pc=EXC_PC and IF/ID becomes a bubble.

## Configuration
- FETCH_ADEL_EN defined: address-error detection as described above.
- FETCH_ADEL_EN not defined:
  - adel_now is constant 0 and if_id_adel stays 0.
  - imem_instr is always captured, and no bounds or alignment logic is synthesized.

## Test plan
- Reset, then release with imem returning 0x2408_0001 at 0x3000 and 0x2409_0002 at 0x3004.
  - Required: if_id_pc = 0x3000, then 0x3004; fetch_cnt = 1, then 2.
- redirect_valid=1, redirect_pc=0x3100 while pc=0x3008, no stall.
  - Required: IF/ID captures 0x3008 (delay slot); next imem_pc = 0x3100.
- stall=1 for 3 cycles with redirect_valid=1 throughout, stall released with redirect_valid dropped.
  - Required: pc and IF/ID frozen for 3 cycles, redirect ignored, fetch_cnt unchanged, sequential fetch resumes.
- exc_req and stall together at pc=0x3010.
  - Required: imem_pc = 0x4180 next, if_id_valid = 0.
  - Then with eret_req=1, epc=0x3010: imem_pc = 0x3010 and another bubble.
- With FETCH_ADEL_EN, redirect to 0x3002, then to 0x7000.
  - Required: if_id_adel=1 and if_id_instr=0 for both, if_id_valid=1, fetch_cnt increments.
  - Without the macro: if_id_adel stays 0 and memory data is captured.
- Assert reset_n=0 mid-stream between clock edges.
  - Required: immediate pc = 0x3000, IF/ID cleared, fetch_cnt = 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: D-stage control, instruction memory port and IF/ID outputs.
// master = fetch_unit side, slave = surrounding pipeline and memory.
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        if_id_adel;
  logic [31:0] fetch_cnt;

  modport master (
    input  stall, redirect_valid, redirect_pc, exc_req, eret_req, epc, imem_instr,
    output imem_pc, if_id_instr, if_id_pc, if_id_valid, if_id_adel, fetch_cnt
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, exc_req, eret_req, epc, imem_instr,
    input  imem_pc, if_id_instr, if_id_pc, if_id_valid, if_id_adel, fetch_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC sequencing, IF/ID capture and fetch counting.
// Define FETCH_ADEL_EN to enable fetch address-error (alignment/window) detection.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter int unsigned ADR_BITS = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic            if_id_adel_q, if_id_adel_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic            adel_now_c;

`ifdef FETCH_ADEL_EN
  // Window end computed on 33 bits so a window touching 2^32 cannot wrap.
  localparam logic [XLEN:0] WIN_LO = (XLEN+1)'(RESET_PC);
  localparam logic [XLEN:0] WIN_HI = WIN_LO + ((XLEN+1)'(1) << (ADR_BITS + 2));

  always_comb begin
    adel_now_c = (pc_q[1:0] != 2'b00)
              || ({1'b0, pc_q} <  WIN_LO)
              || ({1'b0, pc_q} >= WIN_HI);
  end
`else
  assign adel_now_c = 1'b0;
`endif

  // Next PC and IF/ID contents; exception/ERET override stall, stall overrides redirect.
  always_comb begin
    pc_d          = pc_q + XLEN'(4);
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_adel_d  = if_id_adel_q;
    fetch_cnt_d   = fetch_cnt_q;

    if (bus.exc_req) begin
      pc_d = EXC_PC;
    end else if (bus.eret_req) begin
      pc_d = bus.epc;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end

    if (bus.exc_req || bus.eret_req) begin
      if_id_instr_d = '0;
      if_id_pc_d    = '0;
      if_id_valid_d = 1'b0;
      if_id_adel_d  = 1'b0;
    end else if (!bus.stall) begin
      if_id_instr_d = adel_now_c ? '0 : bus.imem_instr;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
      if_id_adel_d  = adel_now_c;
      fetch_cnt_d   = fetch_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      if_id_adel_q  <= 1'b0;
      fetch_cnt_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_adel_q  <= if_id_adel_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign bus.imem_pc     = pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.if_id_adel  = if_id_adel_q;
  assign bus.fetch_cnt   = fetch_cnt_q;

endmodule
